vram_cpu_port: RTL and testbench

CPU-side write/read controller for the two dual-port video RAMs (VRAM32 tile/pattern table, VRAM8 name/colour table). It drives the CPU ports of both VRAMs, which FSX only reads through their GPU ports. It turns a simple start/done bus request into correctly timed VRAM accesses, decodes a 12-bit address into either VRAM, and hides the synchronous RAM read latency. It sits between the future CPU (or a test/boot loader) and the VRAM CPU ports in the FPGC4 top level.

---
 rtl/vram_cpu_port.sv | 185 ++++++++++++++++++
 tb/tb_vram_cpu_port.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_cpu_port.sv
// vram_cpu_port: CPU-side access controller for the VRAM32 and VRAM8 CPU ports.
// Turns a start/done bus request into timed VRAM writes and reads. It decodes
// the 12-bit bus address into one of the two VRAMs and hides the synchronous
// read latency.
// Optional block fill: define VRAM_FILL_EN to add the fill_start/fill_len
// ports and the FILL state.
module vram_cpu_port (
   input  logic        clk,
   input  logic        nreset,
   input  logic        bus_start,
   input  logic        bus_we,
   input  logic [11:0] bus_addr,
   input  logic [31:0] bus_data,
   output logic [31:0] bus_q,
   output logic        bus_busy,
   output logic        bus_done,
   output logic        bus_err,
`ifdef VRAM_FILL_EN
   input  logic        fill_start,
   input  logic [11:0] fill_len,
`endif
   output logic [10:0] vram32_cpu_addr,
   output logic [31:0] vram32_cpu_d,
   output logic        vram32_cpu_we,
   input  logic [31:0] vram32_cpu_q,
   output logic [10:0] vram8_cpu_addr,
   output logic [7:0]  vram8_cpu_d,
   output logic        vram8_cpu_we,
   input  logic [7:0]  vram8_cpu_q
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      RD_ADDR = 3'd2,
      RD_WAIT = 3'd3,
      DONE    = 3'd4
`ifdef VRAM_FILL_EN
      ,
      FILL    = 3'd5
`endif
   } state_t;

   state_t      state;
   logic        sel8;
   logic        hit32;
   logic        hit8;
   logic [10:0] req_index;

   // VRAM32 occupies 0x000-0x47F; VRAM8 occupies 0x800-0xEFF, and its index
   // (addr - 0x800) is simply the low 11 address bits.
   assign hit32     = (bus_addr <= 12'h47F);
   assign hit8      = (bus_addr >= 12'h800) && (bus_addr <= 12'hEFF);
   assign req_index = bus_addr[10:0];

`ifdef VRAM_FILL_EN
   logic [11:0] room;
   logic [11:0] fill_words;
   logic [11:0] remaining;

   // A fill is clipped at the last word of its own VRAM, so it never spills
   // into the other region.
   assign room       = hit8 ? (12'd1792 - {1'b0, req_index})
                            : (12'd1152 - {1'b0, req_index});
   assign fill_words = (fill_len < room) ? fill_len : room;
`endif

   // Request sequencer: every output is registered and changes together with the state.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state           <= IDLE;
         sel8            <= 1'b0;
         bus_q           <= '0;
         bus_busy        <= 1'b0;
         bus_done        <= 1'b0;
         bus_err         <= 1'b0;
         vram32_cpu_addr <= '0;
         vram32_cpu_d    <= '0;
         vram32_cpu_we   <= 1'b0;
         vram8_cpu_addr  <= '0;
         vram8_cpu_d     <= '0;
         vram8_cpu_we    <= 1'b0;
`ifdef VRAM_FILL_EN
         remaining       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus_start) begin
                  bus_busy <= 1'b1;
                  sel8     <= hit8;
                  if (!(hit32 || hit8)) begin
                     state    <= DONE;
                     bus_done <= 1'b1;
                     bus_err  <= 1'b1;
                     if (!bus_we) begin
                        bus_q <= '0;
                     end
                  end else begin
                     if (hit8) begin
                        vram8_cpu_addr <= req_index;
                        vram8_cpu_d    <= bus_data[7:0];
                        vram8_cpu_we   <= bus_we;
                     end else begin
                        vram32_cpu_addr <= req_index;
                        vram32_cpu_d    <= bus_data;
                        vram32_cpu_we   <= bus_we;
                     end
                     state <= bus_we ? WRITE : RD_ADDR;
                  end
               end
`ifdef VRAM_FILL_EN
               else if (fill_start) begin
                  bus_busy <= 1'b1;
                  sel8     <= hit8;
                  if (!(hit32 || hit8)) begin
                     state    <= DONE;
                     bus_done <= 1'b1;
                     bus_err  <= 1'b1;
                  end else if (fill_len == 12'd0) begin
                     state    <= DONE;
                     bus_done <= 1'b1;
                  end else begin
                     if (hit8) begin
                        vram8_cpu_addr <= req_index;
                        vram8_cpu_d    <= bus_data[7:0];
                        vram8_cpu_we   <= 1'b1;
                     end else begin
                        vram32_cpu_addr <= req_index;
                        vram32_cpu_d    <= bus_data;
                        vram32_cpu_we   <= 1'b1;
                     end
                     remaining <= fill_words - 12'd1;
                     state     <= FILL;
                  end
               end
`endif
            end
            WRITE: begin
               vram32_cpu_we <= 1'b0;
               vram8_cpu_we  <= 1'b0;
               bus_done      <= 1'b1;
               state         <= DONE;
            end
            RD_ADDR: begin
               state <= RD_WAIT;
            end
            RD_WAIT: begin
               bus_q    <= sel8 ? {24'h0, vram8_cpu_q} : vram32_cpu_q;
               bus_done <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               bus_done <= 1'b0;
               bus_err  <= 1'b0;
               bus_busy <= 1'b0;
               state    <= IDLE;
            end
`ifdef VRAM_FILL_EN
            FILL: begin
               if (remaining == 12'd0) begin
                  vram32_cpu_we <= 1'b0;
                  vram8_cpu_we  <= 1'b0;
                  bus_done      <= 1'b1;
                  state         <= DONE;
               end else begin
                  remaining <= remaining - 12'd1;
                  if (sel8) begin
                     vram8_cpu_addr <= vram8_cpu_addr + 11'd1;
                  end else begin
                     vram32_cpu_addr <= vram32_cpu_addr + 11'd1;
                  end
               end
            end
`endif
            default: begin
               vram32_cpu_we <= 1'b0;
               vram8_cpu_we  <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_cpu_port.sv
// tb_vram_cpu_port: randomized self-checking bench for vram_cpu_port.
// The bench provides both VRAMs and holds a transaction-level reference model
// that predicts the outputs for every cycle. The same bench covers the
// VRAM_FILL_EN build.
module tb_vram_cpu_port;

   logic        clk;
   logic        nreset;
   logic        bus_start;
   logic        bus_we;
   logic [11:0] bus_addr;
   logic [31:0] bus_data;
   logic [31:0] bus_q;
   logic        bus_busy;
   logic        bus_done;
   logic        bus_err;
`ifdef VRAM_FILL_EN
   logic        fill_start;
   logic [11:0] fill_len;
`endif
   logic [10:0] vram32_cpu_addr;
   logic [31:0] vram32_cpu_d;
   logic        vram32_cpu_we;
   logic [31:0] vram32_cpu_q;
   logic [10:0] vram8_cpu_addr;
   logic [7:0]  vram8_cpu_d;
   logic        vram8_cpu_we;
   logic [7:0]  vram8_cpu_q;

   int total = 0;
   int bad = 0;
   int we32Count = 0;
   int we8Count = 0;
   bit checking = 0;

   // Bench-side VRAM contents and the model's view of them.
   logic [31:0] mem32    [0:2047];
   logic [7:0]  mem8     [0:2047];
   logic [31:0] shadow32 [0:2047];
   logic [7:0]  shadow8  [0:2047];
   logic        ramReady = 1'b0;

   // Reference-model transaction state: length in cycles, current cycle, write cycles.
   int          mLen = 0;
   int          mK = 0;
   int          mWcnt = 0;
   int          mBase = 0;
   bit          mErr = 0;
   bit          mSel8 = 0;
   bit          mIsRead = 0;
   logic [31:0] mData = '0;
   logic [31:0] mQ = '0;

   vram_cpu_port dut (
      .clk             (clk),
      .nreset          (nreset),
      .bus_start       (bus_start),
      .bus_we          (bus_we),
      .bus_addr        (bus_addr),
      .bus_data        (bus_data),
      .bus_q           (bus_q),
      .bus_busy        (bus_busy),
      .bus_done        (bus_done),
      .bus_err         (bus_err),
`ifdef VRAM_FILL_EN
      .fill_start      (fill_start),
      .fill_len        (fill_len),
`endif
      .vram32_cpu_addr (vram32_cpu_addr),
      .vram32_cpu_d    (vram32_cpu_d),
      .vram32_cpu_we   (vram32_cpu_we),
      .vram32_cpu_q    (vram32_cpu_q),
      .vram8_cpu_addr  (vram8_cpu_addr),
      .vram8_cpu_d     (vram8_cpu_d),
      .vram8_cpu_we    (vram8_cpu_we),
      .vram8_cpu_q     (vram8_cpu_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] initVal32(input int i);
      return (32'h9E3779B9 * 32'(i)) + 32'h0000_1234;
   endfunction

   function automatic logic [7:0] initVal8(input int i);
      return 8'((i * 13) + 5);
   endfunction

   // Two synchronous dual-port RAMs: write on we, read data one cycle after the address.
   always @(posedge clk) begin
      if (!ramReady) begin
         for (int i = 0; i < 2048; i++) begin
            mem32[i] <= initVal32(i);
            mem8[i]  <= initVal8(i);
         end
         ramReady <= 1'b1;
      end else begin
         if (vram32_cpu_we) mem32[vram32_cpu_addr] <= vram32_cpu_d;
         if (vram8_cpu_we) mem8[vram8_cpu_addr] <= vram8_cpu_d;
      end
      vram32_cpu_q <= mem32[vram32_cpu_addr];
      vram8_cpu_q  <= mem8[vram8_cpu_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Address map as plain arithmetic: region, index within it and region size.
   function automatic void decode(input logic [11:0] a, output bit hit, output bit is8,
                                  output int idx, output int size);
      int v;
      v = int'(a);
      hit = 0; is8 = 0; idx = 0; size = 0;
      if (v < 1152) begin
         hit = 1; idx = v; size = 1152;
      end else if (v >= 2048 && v < 2048 + 1792) begin
         hit = 1; is8 = 1; idx = v - 2048; size = 1792;
      end
   endfunction

   // One clock of the reference model, evaluated with the inputs sampled at the edge.
   task automatic modelStep();
      bit hit;
      bit is8;
      int idx;
      int size;
      if (mLen != 0 && mK >= 1 && mK <= mWcnt) begin
         if (mSel8) shadow8[mBase + mK - 1] = mData[7:0];
         else shadow32[mBase + mK - 1] = mData;
      end
      if (!nreset) begin
         mLen = 0; mK = 0; mQ = '0;
      end else if (mLen != 0) begin
         if (mK < mLen) begin
            mK++;
            if (mIsRead && mK == mLen)
               mQ = mSel8 ? {24'h0, shadow8[mBase]} : shadow32[mBase];
         end else begin
            mLen = 0; mK = 0;
         end
      end else if (bus_start) begin
         decode(bus_addr, hit, is8, idx, size);
         mK = 1; mSel8 = is8; mBase = idx; mData = bus_data;
         mIsRead = 0; mWcnt = 0; mErr = 0;
         if (!hit) begin
            mLen = 1; mErr = 1;
            if (!bus_we) mQ = '0;
         end else if (bus_we) begin
            mLen = 2; mWcnt = 1;
         end else begin
            mLen = 3; mIsRead = 1;
         end
      end
`ifdef VRAM_FILL_EN
      else if (fill_start) begin
         decode(bus_addr, hit, is8, idx, size);
         mK = 1; mSel8 = is8; mBase = idx; mData = bus_data;
         mIsRead = 0; mWcnt = 0; mErr = 0;
         if (!hit) begin
            mLen = 1; mErr = 1;
         end else begin
            mWcnt = (int'(fill_len) < size - idx) ? int'(fill_len) : size - idx;
            mLen = mWcnt + 1;
         end
      end
`endif
   endtask

   // Model process: advances one step at every rising edge.
   initial begin
      for (int i = 0; i < 2048; i++) begin
         shadow32[i] = initVal32(i);
         shadow8[i]  = initVal8(i);
      end
      forever begin
         @(posedge clk);
         modelStep();
      end
   end

   // Compare process: checks all DUT outputs against the model on every falling edge.
   initial begin
      forever begin
         bit expBusy;
         bit expDone;
         bit exp32;
         bit exp8;
         @(negedge clk);
         we32Count += int'(vram32_cpu_we);
         we8Count  += int'(vram8_cpu_we);
         if (checking) begin
            expBusy = (mLen != 0);
            expDone = expBusy && (mK == mLen);
            exp32   = expBusy && !mSel8 && (mK <= mWcnt);
            exp8    = expBusy && mSel8 && (mK <= mWcnt);
            checkOutput("busy", 32'(bus_busy), 32'(expBusy));
            checkOutput("done", 32'(bus_done), 32'(expDone));
            checkOutput("err", 32'(bus_err), 32'(expDone && mErr));
            checkOutput("bus_q", bus_q, mQ);
            checkOutput("we32", 32'(vram32_cpu_we), 32'(exp32));
            checkOutput("we8", 32'(vram8_cpu_we), 32'(exp8));
            if (exp32) begin
               checkOutput("addr32", 32'(vram32_cpu_addr), 32'(mBase + mK - 1));
               checkOutput("d32", vram32_cpu_d, mData);
            end
            if (exp8) begin
               checkOutput("addr8", 32'(vram8_cpu_addr), 32'(mBase + mK - 1));
               checkOutput("d8", 32'(vram8_cpu_d), 32'(mData[7:0]));
            end
            if (expBusy && mIsRead && mK == 1)
               checkOutput("rd_addr", mSel8 ? 32'(vram8_cpu_addr) : 32'(vram32_cpu_addr), 32'(mBase));
         end
      end
   end

   task automatic waitDone(output int lat, output logic [31:0] q, output logic err);
      bit got;
      got = 0; lat = 0; q = '0; err = 1'b0;
      for (int i = 1; i <= 2100 && !got; i++) begin
         @(negedge clk);
         if (bus_done) begin
            got = 1; lat = i; q = bus_q; err = bus_err;
         end
      end
      checkOutput("done_seen", 32'(got), 32'd1);
   endtask

   task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [31:0] data,
                                output int lat, output logic [31:0] q, output logic err);
      @(posedge clk); #1;
      bus_start = 1'b1; bus_we = we; bus_addr = addr; bus_data = data;
      @(posedge clk); #1;
      bus_start = 1'b0;
      waitDone(lat, q, err);
   endtask

`ifdef VRAM_FILL_EN
   task automatic fillStimulus(input logic [11:0] addr, input logic [31:0] data, input logic [11:0] len,
                               output int lat, output logic [31:0] q, output logic err);
      @(posedge clk); #1;
      fill_start = 1'b1; bus_addr = addr; bus_data = data; fill_len = len;
      @(posedge clk); #1;
      fill_start = 1'b0;
      waitDone(lat, q, err);
   endtask
`endif

   function automatic logic [11:0] randAddr();
      case ($urandom % 6)
         0: return 12'h000 + 12'($urandom % 16);
         1: return 12'h800 + 12'($urandom % 16);
         2: return 12'h478 + 12'($urandom % 16);
         3: return 12'hEF8 + 12'($urandom % 16);
         4: return 12'h7F8 + 12'($urandom % 16);
         default: return 12'($urandom);
      endcase
   endfunction

   // Stimulus: directed scenarios with literal expectations, then random traffic.
   initial begin
      int lat;
      logic [31:0] q;
      logic err;
      int w32;
      int w8;
      int doneCount;
      int doneAt;
      bit idleSeen;
      nreset = 1'b0; bus_start = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_data = '0;
`ifdef VRAM_FILL_EN
      fill_start = 1'b0; fill_len = '0;
`endif
      repeat (3) @(posedge clk);
      #1 nreset = 1'b1;
      @(negedge clk);
      checking = 1;
      checkOutput("reset_busy", 32'(bus_busy), 32'd0);
      checkOutput("reset_done", 32'(bus_done), 32'd0);
      checkOutput("reset_err", 32'(bus_err), 32'd0);
      checkOutput("reset_q", bus_q, 32'd0);
      checkOutput("reset_we32", 32'(vram32_cpu_we), 32'd0);
      checkOutput("reset_we8", 32'(vram8_cpu_we), 32'd0);
      checkOutput("reset_addr32", 32'(vram32_cpu_addr), 32'd0);

      $display("[TB] directed: VRAM32 write/read");
      w32 = we32Count; w8 = we8Count;
      applyStimulus(1'b1, 12'h005, 32'hDEADBEEF, lat, q, err);
      checkOutput("wr32_latency", 32'(lat), 32'd2);
      checkOutput("wr32_we_cycles", 32'(we32Count - w32), 32'd1);
      checkOutput("wr32_mem", mem32[5], 32'hDEADBEEF);
      applyStimulus(1'b0, 12'h005, 32'h0, lat, q, err);
      checkOutput("rd32_latency", 32'(lat), 32'd3);
      checkOutput("rd32_q", q, 32'hDEADBEEF);

      $display("[TB] directed: VRAM8 write/read");
      w32 = we32Count; w8 = we8Count;
      applyStimulus(1'b1, 12'h800, 32'h123456AB, lat, q, err);
      checkOutput("wr8_latency", 32'(lat), 32'd2);
      checkOutput("wr8_we32_cycles", 32'(we32Count - w32), 32'd0);
      checkOutput("wr8_we8_cycles", 32'(we8Count - w8), 32'd1);
      checkOutput("wr8_mem", 32'(mem8[0]), 32'h000000AB);
      applyStimulus(1'b0, 12'h800, 32'h0, lat, q, err);
      checkOutput("rd8_q", q, 32'h000000AB);

      $display("[TB] directed: unmapped accesses");
      w32 = we32Count; w8 = we8Count;
      applyStimulus(1'b0, 12'h480, 32'h0, lat, q, err);
      checkOutput("unmap_rd_latency", 32'(lat), 32'd1);
      checkOutput("unmap_rd_err", 32'(err), 32'd1);
      checkOutput("unmap_rd_q", q, 32'd0);
      applyStimulus(1'b1, 12'h600, 32'hCAFEF00D, lat, q, err);
      checkOutput("unmap_wr_latency", 32'(lat), 32'd1);
      checkOutput("unmap_wr_err", 32'(err), 32'd1);
      checkOutput("unmap_we_cycles", 32'((we32Count - w32) + (we8Count - w8)), 32'd0);

      $display("[TB] directed: repeated start during a read");
      doneCount = 0; doneAt = 0;
      @(posedge clk); #1;
      bus_start = 1'b1; bus_we = 1'b0; bus_addr = 12'h005;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c == 3) bus_start = 1'b0;
         @(negedge clk);
         if (bus_done) begin doneCount++; doneAt = c; end
         if (c <= 4) checkOutput($sformatf("pulse_busy_c%0d", c), 32'(bus_busy), (c <= 3) ? 32'd1 : 32'd0);
      end
      checkOutput("pulse_done_count", 32'(doneCount), 32'd1);
      checkOutput("pulse_done_cycle", 32'(doneAt), 32'd3);
      checkOutput("pulse_q", bus_q, 32'hDEADBEEF);

      $display("[TB] directed: reset during RD_WAIT");
      @(posedge clk); #1;
      bus_start = 1'b1; bus_we = 1'b0; bus_addr = 12'h005;
      @(posedge clk); #1;
      bus_start = 1'b0;
      @(posedge clk); #1;
      nreset = 1'b0;
      @(posedge clk); #1;
      nreset = 1'b1;
      @(negedge clk);
      checkOutput("rst_busy", 32'(bus_busy), 32'd0);
      checkOutput("rst_q", bus_q, 32'd0);
      checkOutput("rst_done", 32'(bus_done), 32'd0);
      doneCount = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus_done) doneCount++;
      end
      checkOutput("rst_no_done", 32'(doneCount), 32'd0);

`ifdef VRAM_FILL_EN
      $display("[TB] directed: clipped fill at the end of VRAM8");
      w32 = we32Count; w8 = we8Count;
      fillStimulus(12'hEFE, 32'h00000077, 12'd5, lat, q, err);
      checkOutput("fill_latency", 32'(lat), 32'd3);
      checkOutput("fill_err", 32'(err), 32'd0);
      checkOutput("fill_we8_cycles", 32'(we8Count - w8), 32'd2);
      checkOutput("fill_we32_cycles", 32'(we32Count - w32), 32'd0);
      checkOutput("fill_mem1790", 32'(mem8[1790]), 32'h77);
      checkOutput("fill_mem1791", 32'(mem8[1791]), 32'h77);
`endif

      $display("[TB] random traffic");
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk); #1;
         bus_start = ($urandom % 4) == 0;
         bus_we    = 1'($urandom % 2);
         bus_addr  = randAddr();
         bus_data  = $urandom;
         nreset    = ($urandom % 250) != 0;
`ifdef VRAM_FILL_EN
         fill_start = ($urandom % 8) == 0;
         fill_len   = (($urandom % 8) == 0) ? 12'($urandom) : 12'($urandom % 6);
`endif
      end
      @(posedge clk); #1;
      bus_start = 1'b0; nreset = 1'b1;
`ifdef VRAM_FILL_EN
      fill_start = 1'b0;
`endif
      idleSeen = 0;
      for (int i = 0; i < 3000 && !idleSeen; i++) begin
         @(negedge clk);
         if (!bus_busy) idleSeen = 1;
      end
      checkOutput("final_idle", 32'(idleSeen), 32'd1);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 2048; i++) begin
         checkOutput($sformatf("mem32[%0d]", i), mem32[i], shadow32[i]);
         checkOutput($sformatf("mem8[%0d]", i), 32'(mem8[i]), 32'(shadow8[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
